// File: rtl/bus_fabric_pkg.sv
// Shared constants for the CPU bus fabric: FSM encoding, error read data and
// the default memory map (REGS, RAM, FLASH).
package bus_fabric_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ERR    = 2'd2;

    localparam logic [7:0] DEF_ERR_DATA = 8'hFF;

    localparam logic [15:0] REGS_BASE  = 16'hFF00;
    localparam logic [15:0] REGS_MASK  = 16'hFF00;
    localparam logic [15:0] RAM_BASE   = 16'h0000;
    localparam logic [15:0] RAM_MASK   = 16'h8000;
    localparam logic [15:0] FLASH_BASE = 16'h8000;
    localparam logic [15:0] FLASH_MASK = 16'h8000;

    // Slice 0 is the lowest-index target, so REGS wins over FLASH at 0xFF00.
    localparam logic [47:0] DEF_REGION_BASE = {FLASH_BASE, RAM_BASE, REGS_BASE};
    localparam logic [47:0] DEF_REGION_MASK = {FLASH_MASK, RAM_MASK, REGS_MASK};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask region decoder; the lowest matching index wins.
module bus_addr_decoder
    import bus_fabric_pkg::*;
#(
    parameter int                            NUM_TARGETS = 3,
    parameter int                            ADDR_W      = 16,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter int                            IDX_W       = idx_width(NUM_TARGETS)
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic                   hit,
    output logic [NUM_TARGETS-1:0] sel,
    output logic [IDX_W-1:0]       idx
);

    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        // Scan downwards so the last assignment is the lowest matching index.
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Address-decoding interconnect from the CPU bus master to N targets, with
// wait tracking, timeout watchdog, error completion and sticky error status.
//
// state     | meaning
// ST_IDLE   | no access in flight; decode and route combinationally
// ST_ACTIVE | waiting on latched target, timeout counter running
// ST_ERR    | error completion cycle, returns ERR_DATA and logs the error
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                            NUM_TARGETS    = 3,
    parameter int                            ADDR_W         = 16,
    parameter int                            DATA_W         = 8,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_BASE    = DEF_REGION_BASE,
    parameter logic [NUM_TARGETS*ADDR_W-1:0] REGION_MASK    = DEF_REGION_MASK,
    parameter int                            TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0]             ERR_DATA       = DEF_ERR_DATA,
    parameter int                            ERR_COUNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    input  logic                          m_read,
    input  logic                          m_write,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_wait,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [NUM_TARGETS-1:0]        s_read,
    output logic [NUM_TARGETS-1:0]        s_write,
    input  logic [NUM_TARGETS*DATA_W-1:0] s_rdata,
    input  logic [NUM_TARGETS-1:0]        s_wait,
    input  logic                          err_clear,
    output logic                          err_flag,
    output logic [ADDR_W-1:0]             err_addr,
    output logic [ERR_COUNT_W-1:0]        err_count
);

    localparam int IDX_W = idx_width(NUM_TARGETS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0]       tgt_idx, tgt_idx_nxt;
    logic                   dec_hit;
    logic [NUM_TARGETS-1:0] dec_sel;
    logic [IDX_W-1:0]       dec_idx;
    logic [NUM_TARGETS-1:0] rd_strobe, wr_strobe;
    logic                   req;

    bus_addr_decoder #(
        .NUM_TARGETS (NUM_TARGETS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .IDX_W       (IDX_W)
    ) u_decoder (
        .addr (m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel),
        .idx  (dec_idx)
    );

    assign req     = m_read | m_write;
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;
    // Strobes are gated by reset so a held request cannot leak through while aborted.
    assign s_read  = rst ? '0 : rd_strobe;
    assign s_write = rst ? '0 : wr_strobe;

    always_comb begin
        rd_strobe   = '0;
        wr_strobe   = '0;
        m_wait      = 1'b0;
        m_rdata     = '0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        tgt_idx_nxt = tgt_idx;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (req) begin
                    if (!dec_hit || (m_read && m_write)) begin
                        m_wait    = 1'b1;
                        state_nxt = ST_ERR;
                    end else begin
                        rd_strobe = dec_sel & {NUM_TARGETS{m_read}};
                        wr_strobe = dec_sel & {NUM_TARGETS{m_write}};
                        m_rdata   = s_rdata[dec_idx*DATA_W +: DATA_W];
                        m_wait    = s_wait[dec_idx];
                        if (s_wait[dec_idx]) begin
                            tgt_idx_nxt = dec_idx;
                            cnt_nxt     = CNT_W'(1);
                            state_nxt   = ST_ACTIVE;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                if (!req) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    m_rdata = s_rdata[tgt_idx*DATA_W +: DATA_W];
                    m_wait  = s_wait[tgt_idx];
                    if (!s_wait[tgt_idx]) begin
                        rd_strobe[tgt_idx] = m_read;
                        wr_strobe[tgt_idx] = m_write;
                        cnt_nxt            = '0;
                        state_nxt          = ST_IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_VAL)) begin
                        state_nxt = ST_ERR;
                    end else begin
                        rd_strobe[tgt_idx] = m_read;
                        wr_strobe[tgt_idx] = m_write;
                        if (cnt != '1) begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end
            ST_ERR: begin
                m_rdata   = ERR_DATA;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tgt_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tgt_idx <= tgt_idx_nxt;
        end
    end

    // A new error in the same cycle as err_clear takes precedence over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (state == ST_ERR) begin
            err_flag <= 1'b1;
            err_addr <= m_addr;
            if (err_clear) begin
                err_count <= ERR_COUNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end else if (err_clear) begin
            err_flag  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end
    end

endmodule
